// File: rtl/mult_hazard_controller.sv
// ---------------------------------------------------------------------------
// mult_hazard_controller
//
// Hazard and sequencing controller for a 5-stage RISC-V pipeline that has a
// multi-cycle multiplier in EX. It detects load-use hazards and taken-branch
// flushes, and runs the multiplier start/busy/done sequence. From these it
// drives the stall, flush and bubble controls for PC, IF/ID, ID/EX and
// EX/MEM. ALU-to-ALU dependencies are left to the forwarding unit.
//
// Parameters:
//   MULT_LAT    total EX-stage cycles of a multiply (legal range 2..16)
//   REG_ADDR_W  register-index width
//
// Ports:
//   clk, arst_n           clock; synchronous active-low reset
//   rs1_IF_ID, rs2_IF_ID  source registers of the instruction in ID
//   use_rs1/2_IF_ID       the ID instruction really reads rs1 / rs2
//   rd_ID_EX              destination of the instruction in EX
//   mem_read_ID_EX        EX instruction is a load
//   is_mult_ID_EX         EX instruction is a valid multiply
//   branch_taken_EX_MEM   taken branch/jump resolved in MEM
//   stall_pc/if_id/id_ex  hold the PC / IF/ID / ID/EX registers
//   flush_if_id           zero IF/ID
//   flush_id_ex           load a bubble into ID/EX
//   bubble_ex_mem         load a bubble into EX/MEM
//   mult_start            one-cycle multiplier launch
//   mult_busy             a multiply occupies EX
//   mult_done             multiplier result valid this cycle
//   mult_abort            in-flight multiply cancelled by a flush
//   fsm_state             debug view of the FSM (0 = IDLE, 1 = BUSY)
//
// Optional feature (macro HAZARD_PERF_CNT_EN):
//   adds load_use_stalls[31:0] and mult_stalls[31:0] performance counters.
//   Both wrap at 2^32 and clear on reset. When the macro is undefined the
//   ports and counters are absent and the control behaviour is unchanged.
//
// Handshake: mult_start is a single-cycle pulse; the multiplier result is
// captured by EX/MEM in the one cycle where mult_done is high, because that
// is the only multiply cycle with neither a stall nor a bubble.
// ---------------------------------------------------------------------------
module mult_hazard_controller #(
    parameter int MULT_LAT   = 4,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic [REG_ADDR_W-1:0] rs1_IF_ID,
    input  logic [REG_ADDR_W-1:0] rs2_IF_ID,
    input  logic                  use_rs1_IF_ID,
    input  logic                  use_rs2_IF_ID,
    input  logic [REG_ADDR_W-1:0] rd_ID_EX,
    input  logic                  mem_read_ID_EX,
    input  logic                  is_mult_ID_EX,
    input  logic                  branch_taken_EX_MEM,
    output logic                  stall_pc,
    output logic                  stall_if_id,
    output logic                  stall_id_ex,
    output logic                  flush_if_id,
    output logic                  flush_id_ex,
    output logic                  bubble_ex_mem,
    output logic                  mult_start,
    output logic                  mult_busy,
    output logic                  mult_done,
    output logic                  mult_abort,
    output logic                  fsm_state
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]           load_use_stalls,
    output logic [31:0]           mult_stalls
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // BUSY is entered after the start cycle and ends with the done cycle,
    // so the counter starts two below the total latency.
    localparam logic [3:0] CNT_INIT = 4'(MULT_LAT - 2);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic [3:0] cnt_nxt;
    logic       load_use;

    // Raw load-use condition; whether it is acted on depends on the FSM and
    // the higher-priority branch flush. x0 is never a real dependency.
    always_comb begin
        load_use = mem_read_ID_EX && (rd_ID_EX != '0) &&
                   ((use_rs1_IF_ID && (rs1_IF_ID == rd_ID_EX)) ||
                    (use_rs2_IF_ID && (rs2_IF_ID == rd_ID_EX)));
    end

    // -----------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // -----------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (branch_taken_EX_MEM) begin
            state_nxt = IDLE;
            cnt_nxt   = 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (is_mult_ID_EX) begin
                        state_nxt = BUSY;
                        cnt_nxt   = CNT_INIT;
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt_nxt = cnt - 4'd1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------
    // Output logic: priority is branch flush > multiply > load-use
    // -----------------------------------------------------------------
    always_comb begin
        stall_pc      = 1'b0;
        stall_if_id   = 1'b0;
        stall_id_ex   = 1'b0;
        flush_if_id   = 1'b0;
        flush_id_ex   = 1'b0;
        bubble_ex_mem = 1'b0;
        mult_start    = 1'b0;
        mult_busy     = 1'b0;
        mult_done     = 1'b0;
        mult_abort    = 1'b0;
        if (branch_taken_EX_MEM) begin
            // Wrong-path instructions are squashed; a multiply in EX is one
            // of them, so it is cancelled rather than started or completed.
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
            mult_abort  = (state == BUSY) || is_mult_ID_EX;
        end else if (state == BUSY) begin
            mult_busy = 1'b1;
            if (cnt != 4'd0) begin
                stall_pc      = 1'b1;
                stall_if_id   = 1'b1;
                stall_id_ex   = 1'b1;
                bubble_ex_mem = 1'b1;
            end else begin
                // Final cycle: pipeline advances and EX/MEM takes the product.
                mult_done = 1'b1;
            end
        end else if (is_mult_ID_EX) begin
            mult_start    = 1'b1;
            mult_busy     = 1'b1;
            stall_pc      = 1'b1;
            stall_if_id   = 1'b1;
            stall_id_ex   = 1'b1;
            bubble_ex_mem = 1'b1;
        end else if (load_use) begin
            stall_pc    = 1'b1;
            stall_if_id = 1'b1;
            flush_id_ex = 1'b1;
        end
    end

    assign fsm_state = state;

`ifdef HAZARD_PERF_CNT_EN
    logic lu_stall_evt;
    logic mult_stall_evt;

    // Load-use stalls are recognisable by the ID/EX flush that accompanies
    // stall_pc; multiply stalls hold ID/EX instead of flushing it.
    always_comb begin
        lu_stall_evt   = stall_pc && flush_id_ex;
        mult_stall_evt = stall_pc && stall_id_ex;
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            load_use_stalls <= 32'd0;
            mult_stalls     <= 32'd0;
        end else begin
            if (lu_stall_evt) begin
                load_use_stalls <= load_use_stalls + 32'd1;
            end
            if (mult_stall_evt) begin
                mult_stalls <= mult_stalls + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mult_hazard_controller.sv
// ---------------------------------------------------------------------------
// Directed self-checking bench for mult_hazard_controller (MULT_LAT = 4).
// Inputs change 1 ns after a rising edge; outputs are sampled a further 1 ns
// later, well away from the next edge.
// Output vector bit order:
//   [9] stall_pc [8] stall_if_id [7] stall_id_ex [6] flush_if_id
//   [5] flush_id_ex [4] bubble_ex_mem [3] mult_start [2] mult_busy
//   [1] mult_done [0] mult_abort
// ---------------------------------------------------------------------------
module tb_mult_hazard_controller;

    localparam logic [9:0] O_NONE  = 10'b0000000000;
    localparam logic [9:0] O_START = 10'b1110011100;
    localparam logic [9:0] O_STALL = 10'b1110010100;
    localparam logic [9:0] O_DONE  = 10'b0000000110;
    localparam logic [9:0] O_LU    = 10'b1100100000;
    localparam logic [9:0] O_FLA   = 10'b0001100001;
    localparam logic [9:0] O_FL    = 10'b0001100000;

    logic       clk = 1'b0;
    logic       arst_n;
    logic [4:0] rs1_IF_ID, rs2_IF_ID, rd_ID_EX;
    logic       use_rs1_IF_ID, use_rs2_IF_ID;
    logic       mem_read_ID_EX, is_mult_ID_EX, branch_taken_EX_MEM;
    logic       stall_pc, stall_if_id, stall_id_ex, flush_if_id, flush_id_ex;
    logic       bubble_ex_mem, mult_start, mult_busy, mult_done, mult_abort;
    logic       fsm_state;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] load_use_stalls, mult_stalls;
`endif

    int checks = 0;
    int errors = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    mult_hazard_controller #(.MULT_LAT(4), .REG_ADDR_W(5)) dut (
        .clk                 (clk),
        .arst_n              (arst_n),
        .rs1_IF_ID           (rs1_IF_ID),
        .rs2_IF_ID           (rs2_IF_ID),
        .use_rs1_IF_ID       (use_rs1_IF_ID),
        .use_rs2_IF_ID       (use_rs2_IF_ID),
        .rd_ID_EX            (rd_ID_EX),
        .mem_read_ID_EX      (mem_read_ID_EX),
        .is_mult_ID_EX       (is_mult_ID_EX),
        .branch_taken_EX_MEM (branch_taken_EX_MEM),
        .stall_pc            (stall_pc),
        .stall_if_id         (stall_if_id),
        .stall_id_ex         (stall_id_ex),
        .flush_if_id         (flush_if_id),
        .flush_id_ex         (flush_id_ex),
        .bubble_ex_mem       (bubble_ex_mem),
        .mult_start          (mult_start),
        .mult_busy           (mult_busy),
        .mult_done           (mult_done),
        .mult_abort          (mult_abort),
        .fsm_state           (fsm_state)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .load_use_stalls     (load_use_stalls),
        .mult_stalls         (mult_stalls)
`endif
    );

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rs1_IF_ID           = 5'd0;
        rs2_IF_ID           = 5'd0;
        rd_ID_EX            = 5'd0;
        use_rs1_IF_ID       = 1'b0;
        use_rs2_IF_ID       = 1'b0;
        mem_read_ID_EX      = 1'b0;
        is_mult_ID_EX       = 1'b0;
        branch_taken_EX_MEM = 1'b0;
    endtask

    task automatic set_load(input logic [4:0] rd, input logic [4:0] rs1,
                            input logic u1, input logic [4:0] rs2,
                            input logic u2);
        mem_read_ID_EX = 1'b1;
        rd_ID_EX       = rd;
        rs1_IF_ID      = rs1;
        use_rs1_IF_ID  = u1;
        rs2_IF_ID      = rs2;
        use_rs2_IF_ID  = u2;
    endtask

    // ---------------- checkers ----------------
    task automatic chk_out(input string tag, input logic [9:0] expected);
        logic [9:0] observed;
        #1;
        observed = {stall_pc, stall_if_id, stall_id_ex, flush_if_id,
                    flush_id_ex, bubble_ex_mem, mult_start, mult_busy,
                    mult_done, mult_abort};
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic chk_state(input string tag, input logic expected);
        checks++;
        assert (fsm_state === expected) else begin
            errors++;
            $error("FAIL %s state observed=%b expected=%b", tag, fsm_state, expected);
        end
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic chk_perf(input string tag, input logic [31:0] exp_lu,
                            input logic [31:0] exp_mu);
        checks++;
        assert (load_use_stalls === exp_lu && mult_stalls === exp_mu) else begin
            errors++;
            $error("FAIL %s lu=%0d mult=%0d expected lu=%0d mult=%0d",
                   tag, load_use_stalls, mult_stalls, exp_lu, exp_mu);
        end
    endtask
`endif

    // ---------------- directed sequence ----------------
    initial begin
        idle_inputs();
        arst_n = 1'b0;
        tick();
        tick();
        chk_out("reset_outputs", O_NONE);
        chk_state("reset_state", 1'b0);
`ifdef HAZARD_PERF_CNT_EN
        chk_perf("reset_perf", 32'd0, 32'd0);
`endif
        arst_n = 1'b1;
        tick();
        chk_out("idle_quiet", O_NONE);

        // Single multiply followed immediately by a second one.
        is_mult_ID_EX = 1'b1;
        chk_out("mul_t0_start", O_START);
        tick(); chk_out("mul_t1_stall", O_STALL);
        chk_state("mul_t1_busy", 1'b1);
        tick(); chk_out("mul_t2_stall", O_STALL);
        tick(); chk_out("mul_t3_done", O_DONE);
        tick(); chk_out("mul_t4_restart", O_START);
        tick(); chk_out("mul_t5_stall", O_STALL);
        tick(); chk_out("mul_t6_stall", O_STALL);
        tick(); chk_out("mul_t7_done", O_DONE);
        tick();
        is_mult_ID_EX = 1'b0;
        chk_out("mul_after_idle", O_NONE);
        chk_state("mul_after_state", 1'b0);

        // Load-use via rs2, then via rs1, then non-hazards.
        set_load(5'd5, 5'd3, 1'b1, 5'd5, 1'b1);
        chk_out("lu_rs2_x5", O_LU);
        tick();
        chk_state("lu_no_state_change", 1'b0);
        idle_inputs();
        chk_out("lu_released", O_NONE);
        set_load(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
        chk_out("lu_x0_no_stall", O_NONE);
        set_load(5'd7, 5'd7, 1'b1, 5'd2, 1'b1);
        chk_out("lu_rs1_x7", O_LU);
        set_load(5'd7, 5'd7, 1'b0, 5'd2, 1'b1);
        chk_out("lu_rs1_unused", O_NONE);
        set_load(5'd9, 5'd9, 1'b1, 5'd9, 1'b1);
        mem_read_ID_EX = 1'b0;
        chk_out("lu_not_load", O_NONE);
        tick();
        idle_inputs();

        // Branch while idle beats a load-use; branch with multiply in EX.
        set_load(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
        branch_taken_EX_MEM = 1'b1;
        chk_out("br_over_lu", O_FL);
        idle_inputs();
        branch_taken_EX_MEM = 1'b1;
        is_mult_ID_EX = 1'b1;
        chk_out("br_idle_mult_abort", O_FLA);
        tick();
        chk_state("br_idle_mult_no_busy", 1'b0);

        // Branch at T1 of a multiply.
        idle_inputs();
        is_mult_ID_EX = 1'b1;
        chk_out("brm_t0_start", O_START);
        tick();
        branch_taken_EX_MEM = 1'b1;
        chk_out("brm_t1_abort", O_FLA);
        tick();
        idle_inputs();
        chk_state("brm_t2_idle", 1'b0);
        chk_out("brm_t2_quiet", O_NONE);
        tick(); chk_out("brm_t3_no_done", O_NONE);

        // Load-use condition present while BUSY: only multiply controls.
        is_mult_ID_EX = 1'b1;
        chk_out("bl_t0_start", O_START);
        tick(); chk_out("bl_t1_stall", O_STALL);
        tick();
        set_load(5'd5, 5'd0, 1'b0, 5'd5, 1'b1);
        chk_out("bl_t2_cnt1_no_lu", O_STALL);
        tick(); chk_out("bl_t3_done_no_lu", O_DONE);
        tick();
        idle_inputs();
        chk_out("bl_after", O_NONE);

        // Reset asserted at BUSY cnt=2.
        tick();
        is_mult_ID_EX = 1'b1;
        chk_out("rst_t0_start", O_START);
        tick();
        is_mult_ID_EX = 1'b0;
        arst_n = 1'b0;
        chk_out("rst_t1_stall", O_STALL);
        tick();
        chk_out("rst_after_edge", O_NONE);
        chk_state("rst_after_state", 1'b0);
`ifdef HAZARD_PERF_CNT_EN
        chk_perf("rst_perf_clear", 32'd0, 32'd0);
`endif
        arst_n = 1'b1;
        tick(); chk_out("rst_no_done_abort", O_NONE);

        // One multiply plus one load-use after reset.
        is_mult_ID_EX = 1'b1;
        chk_out("pm_t0", O_START);
        tick(); chk_out("pm_t1", O_STALL);
        tick(); chk_out("pm_t2", O_STALL);
        tick(); chk_out("pm_t3", O_DONE);
        tick();
        is_mult_ID_EX = 1'b0;
        set_load(5'd12, 5'd12, 1'b1, 5'd0, 1'b0);
        chk_out("pl_lu", O_LU);
        tick();
        idle_inputs();
        chk_out("pl_done", O_NONE);
`ifdef HAZARD_PERF_CNT_EN
        chk_perf("perf_totals", 32'd1, 32'd3);
`endif

        // ---------------- report ----------------
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time bound in case the sequence above ever stalls.
    initial begin
        #20000;
        $display("FAIL timeout sequence did not complete");
        $fatal(1, "timeout");
    end

endmodule
